// File: rtl/peripheral_gpio_wb_bridge32.sv
// Wishbone bridge: 32-bit upstream slave port to 8-bit downstream GPIO master.
// Each selected byte lane becomes one downstream access. Lanes are issued in
// ascending order with one idle cycle between them. A stuck downstream access
// is terminated with an upstream error after TIMEOUT cycles.
module peripheral_gpio_wb_bridge32 #(
   parameter int TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   // upstream 32-bit slave port
   input  logic [2:0]  wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   input  logic        wbs_we_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic [3:0]  wbs_sel_i,
   output logic        wbs_ack_o,
   output logic        wbs_err_o,
   // downstream 8-bit master port
   output logic [2:0]  wbm_adr_o,
   output logic [7:0]  wbm_dat_o,
   input  logic [7:0]  wbm_dat_i,
   output logic        wbm_we_o,
   output logic        wbm_stb_o,
   output logic        wbm_cyc_o,
   output logic [3:0]  wbm_sel_o,
   input  logic        wbm_ack_i
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACCESS = 3'd1;
   localparam logic [2:0] S_GAP    = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_ERR    = 3'd4;

   logic [2:0]  state;
   logic        req_adr2;
   logic        req_we;
   logic [31:0] req_dat;
   logic [3:0]  mask;      // byte lanes still to be transferred
   logic [7:0]  wait_cnt;  // ACCESS cycles spent without a downstream ack
   logic [31:0] rdata;     // assembled upstream read word
   logic [1:0]  lane;
   logic [3:0]  lane_onehot;
   logic [3:0]  mask_next;

   // Current lane is the lowest pending byte lane.
   always_comb begin
      // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
      lane = 2'd0;
      casez (mask)
         4'b???1: lane = 2'd0;
         4'b??10: lane = 2'd1;
         4'b?100: lane = 2'd2;
         4'b1000: lane = 2'd3;
         default: lane = 2'd0;
      endcase
      lane_onehot = 4'b0001 << lane;
      mask_next   = mask & ~lane_onehot;
   end

   // Output decode from state and request registers only; no upstream input reaches these.
   always_comb begin
      wbs_ack_o = (state == S_DONE);
      wbs_err_o = (state == S_ERR);
      wbs_dat_o = (state == S_DONE) ? rdata : 32'h0;
      wbm_cyc_o = 1'b0;
      wbm_stb_o = 1'b0;
      wbm_we_o  = 1'b0;
      wbm_adr_o = 3'd0;
      wbm_sel_o = 4'd0;
      wbm_dat_o = 8'd0;
      if (state == S_ACCESS) begin
         wbm_cyc_o = 1'b1;
         wbm_stb_o = 1'b1;
         wbm_we_o  = req_we;
         wbm_adr_o = {req_adr2, lane};
         wbm_sel_o = lane_onehot;
         wbm_dat_o = req_dat[{lane, 3'b000} +: 8];
      end
   end

   // Transfer sequencer: request capture, lane stepping, timeout and abort.
   always_ff @(posedge wb_clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (wb_rst_i) begin
         state    <= S_IDLE;
         req_adr2 <= 1'b0;
         req_we   <= 1'b0;
         req_dat  <= 32'h0;
         mask     <= 4'h0;
         wait_cnt <= 8'h0;
         rdata    <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (wbs_cyc_i && wbs_stb_i) begin
                  req_adr2 <= wbs_adr_i[2];
                  req_we   <= wbs_we_i;
                  req_dat  <= wbs_dat_i;
                  mask     <= wbs_sel_i;
                  rdata    <= 32'h0;
                  wait_cnt <= 8'h0;
                  state    <= (wbs_sel_i != 4'h0) ? S_ACCESS : S_DONE;
               end
            end
            S_ACCESS: begin
               if (!wbs_cyc_i) begin
                  mask  <= 4'h0;
                  state <= S_IDLE;
               end else if (wbm_ack_i) begin
                  if (!req_we) rdata[{lane, 3'b000} +: 8] <= wbm_dat_i;
                  mask  <= mask_next;
                  state <= (mask_next != 4'h0) ? S_GAP : S_DONE;
               end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                  // remaining lanes are dropped without any downstream access
                  mask  <= 4'h0;
                  state <= S_ERR;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_GAP: begin
               if (!wbs_cyc_i) begin
                  mask  <= 4'h0;
                  state <= S_IDLE;
               end else begin
                  wait_cnt <= 8'h0;
                  state    <= S_ACCESS;
               end
            end
            S_DONE:  state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_peripheral_gpio_wb_bridge32.sv
// Bench for the 32-to-8 bit Wishbone GPIO bridge: directed vector table,
// abort and mid-access reset sequences, then random transfers against a
// lane-by-lane reference model and a behavioural downstream slave.
module tb_peripheral_gpio_wb_bridge32;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  wbs_adr_i = '0;
   logic [31:0] wbs_dat_i = '0;
   logic [31:0] wbs_dat_o;
   logic        wbs_we_i = 1'b0, wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0;
   logic [3:0]  wbs_sel_i = '0;
   logic        wbs_ack_o, wbs_err_o;
   logic [2:0]  wbm_adr_o;
   logic [7:0]  wbm_dat_o;
   logic [7:0]  wbm_dat_i = '0;
   logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_ack_i = 1'b0;

   always #5 clk = ~clk;

   peripheral_gpio_wb_bridge32 #(.TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
      .wbs_we_i(wbs_we_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
      .wbs_sel_i(wbs_sel_i), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
      .wbm_sel_o(wbm_sel_o), .wbm_ack_i(wbm_ack_i)
   );

   typedef struct {
      logic [2:0] adr;
      logic       we;
      logic [7:0] dat;
   } acc_t;

   typedef struct {
      logic [2:0]  adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          w;       // slave wait states; >= 100 means never ack
      bit          e_ack;
      bit          e_err;
      int          e_cyc;
      logic [31:0] e_rd;
      int          e_stb;   // total cycles with wbm_stb_o high
      logic [7:0]  e_seen;  // downstream addresses that saw stb
   } vec_t;

   // downstream GPIO register file (slave side) and the model's own copy
   logic [7:0] mem     [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   logic [7:0] ref_mem [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

   int   slave_wait  = 0;
   bit   slave_noise = 1'b0;
   int   wcount      = 0;
   acc_t log_q[$];
   acc_t exp_q[$];
   int   stb_cycles  = 0;
   logic [7:0] stb_seen = '0;
   int   both_cnt = 0;
   int   sel_bad  = 0;
   int   n_checks = 0;
   int   n_err    = 0;

   // Behavioural slave: acks after slave_wait stalled cycles, stray acks when idle.
   always @(negedge clk) begin
      if (wbm_cyc_o && wbm_stb_o) begin
         stb_cycles++;
         stb_seen[wbm_adr_o] = 1'b1;
         if (wbm_sel_o != (4'b0001 << wbm_adr_o[1:0])) sel_bad++;
         if (slave_wait < 100 && wcount >= slave_wait) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = mem[wbm_adr_o];
            log_q.push_back('{wbm_adr_o, wbm_we_o, wbm_dat_o});
            if (wbm_we_o) mem[wbm_adr_o] = wbm_dat_o;
            wcount = 0;
         end else begin
            wbm_ack_i = 1'b0;
            wbm_dat_i = 8'($urandom);
            wcount++;
         end
      end else begin
         wcount    = 0;
         wbm_ack_i = slave_noise && ($urandom_range(0, 3) == 0);
         wbm_dat_i = 8'($urandom);
      end
      if (wbs_ack_o && wbs_err_o) both_cnt++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Reference model: one downstream access per selected lane, ascending;
   // each access takes w+1 cycles, one idle cycle between accesses.
   task automatic model(input logic [2:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input int w,
                        output bit e_ack, output bit e_err, output int e_cyc,
                        output logic [31:0] e_rd);
      int t;
      logic [2:0] a;
      exp_q.delete();
      e_rd  = 32'h0;
      e_err = 1'b0;
      e_ack = 1'b1;
      t     = 1;
      e_cyc = 1;
      if (sel == 4'h0) return;
      for (int ln = 0; ln < 4; ln++) begin
         if (sel[ln]) begin
            a = {adr[2], 2'(ln)};
            if (w >= TO) begin
               e_ack = 1'b0;
               e_err = 1'b1;
               e_cyc = t + TO;
               return;
            end
            exp_q.push_back('{a, we, dat[8*ln +: 8]});
            if (we) ref_mem[a] = dat[8*ln +: 8];
            else    e_rd[8*ln +: 8] = ref_mem[a];
            t += w + 1;
            if ((sel >> (ln + 1)) != 4'h0) t += 1;
         end
      end
      e_cyc = t;
   endtask

   // Issue one upstream transfer; called and returns at 1 time unit after a rising edge.
   task automatic run_txn(input logic [2:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] dat, output bit ack, output bit err,
                          output int cyc_n, output logic [31:0] rd);
      log_q.delete();
      stb_cycles = 0;
      stb_seen   = '0;
      wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      ack = 1'b0; err = 1'b0; cyc_n = -1; rd = 32'h0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if (wbs_ack_o || wbs_err_o) begin
            ack = wbs_ack_o; err = wbs_err_o; rd = wbs_dat_o; cyc_n = c;
            break;
         end
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      if (cyc_n < 0) check("termination_bound", 32'(cyc_n), 32'd0);
      @(posedge clk); #1;
      check("term_pulse_one_cycle", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
   endtask

   task automatic compare_log(input string name);
      check({name, "_acc_count"}, 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         check({name, "_acc_adr"}, 32'(log_q[i].adr), 32'(exp_q[i].adr));
         check({name, "_acc_we"}, 32'(log_q[i].we), 32'(exp_q[i].we));
         if (exp_q[i].we) check({name, "_acc_dat"}, 32'(log_q[i].dat), 32'(exp_q[i].dat));
      end
   endtask

   vec_t vecs[7];

   initial begin
      bit ack, err, e_ack, e_err;
      int cyc_n, e_cyc;
      logic [31:0] rd, e_rd;

      vecs[0] = '{3'd0, 1'b0, 4'b0101, 32'h0,        0,   1, 0, 4,  32'h0033_0011, 2, 8'h05};
      vecs[1] = '{3'd4, 1'b1, 4'b1111, 32'hA1B2C3D4, 0,   1, 0, 8,  32'h0,         4, 8'hF0};
      vecs[2] = '{3'd4, 1'b0, 4'b1111, 32'h0,        0,   1, 0, 8,  32'hA1B2C3D4,  4, 8'hF0};
      vecs[3] = '{3'd5, 1'b0, 4'b0000, 32'hFFFFFFFF, 0,   1, 0, 1,  32'h0,         0, 8'h00};
      vecs[4] = '{3'd0, 1'b1, 4'b0011, 32'h0000_5A5A, 200, 0, 1, 5,  32'h0,         4, 8'h01};
      vecs[5] = '{3'd7, 1'b0, 4'b1000, 32'h0,        2,   1, 0, 4,  32'hA100_0000, 3, 8'h80};
      vecs[6] = '{3'd0, 1'b0, 4'b0011, 32'h0,        3,   1, 0, 10, 32'h0000_2211, 8, 8'h03};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_wbs_dat_o", wbs_dat_o, 32'h0);
      check("reset_ctrl_outputs",
            {12'd0, wbs_ack_o, wbs_err_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o},
            32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // directed vector table
      foreach (vecs[i]) begin
         slave_wait = vecs[i].w;
         model(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].dat, vecs[i].w, e_ack, e_err, e_cyc, e_rd);
         run_txn(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].dat, ack, err, cyc_n, rd);
         check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].e_ack));
         check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].e_err));
         check($sformatf("vec%0d_cycles", i), 32'(cyc_n), 32'(vecs[i].e_cyc));
         if (vecs[i].e_ack) check($sformatf("vec%0d_rdata", i), rd, vecs[i].e_rd);
         check($sformatf("vec%0d_stb_cycles", i), 32'(stb_cycles), 32'(vecs[i].e_stb));
         check($sformatf("vec%0d_stb_adrs", i), 32'(stb_seen), 32'(vecs[i].e_seen));
         compare_log($sformatf("vec%0d", i));
      end

      // upstream abort while the second lane is stalled
      slave_wait = 3;
      log_q.delete();
      wbs_adr_i = 3'd0; wbs_we_i = 1'b1; wbs_sel_i = 4'b0011; wbs_dat_i = 32'h0000_BEEF;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1;
         if (c == 6) check("abort_lane1_active", {wbm_stb_o, wbm_adr_o}, {1'b1, 3'd1});
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(posedge clk); #1;
      check("abort_downstream_idle", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
      for (int c = 0; c < 4; c++) begin
         check("abort_no_term", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
         @(posedge clk); #1;
      end
      check("abort_lane0_written", 32'(mem[0]), 32'hEF);
      check("abort_lane1_untouched", 32'(mem[1]), 32'(ref_mem[1]));
      ref_mem[0] = 8'hEF;
      slave_wait = 0;
      model(3'd0, 1'b0, 4'b0011, 32'h0, 0, e_ack, e_err, e_cyc, e_rd);
      run_txn(3'd0, 1'b0, 4'b0011, 32'h0, ack, err, cyc_n, rd);
      check("post_abort_ack", 32'(ack), 32'd1);
      check("post_abort_rdata", rd, e_rd);
      check("post_abort_cycles", 32'(cyc_n), 32'(e_cyc));

      // reset pulsed mid-access
      slave_wait = 200;
      wbs_adr_i = 3'd4; wbs_we_i = 1'b1; wbs_sel_i = 4'b0110; wbs_dat_i = 32'h0123_4567;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_seq_stb_high", 32'(wbm_stb_o), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_wbs_dat_o", wbs_dat_o, 32'h0);
      check("rst_mid_ctrl_outputs",
            {12'd0, wbs_ack_o, wbs_err_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o},
            32'h0);
      rst = 1'b0;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(posedge clk); #1;
      slave_wait = 0;
      model(3'd4, 1'b0, 4'b1000, 32'h0, 0, e_ack, e_err, e_cyc, e_rd);
      run_txn(3'd4, 1'b0, 4'b1000, 32'h0, ack, err, cyc_n, rd);
      check("post_rst_ack", 32'(ack), 32'd1);
      check("post_rst_cycles", 32'(cyc_n), 32'd2);
      check("post_rst_rdata", rd, e_rd);
      compare_log("post_rst");

      // random transfers with stray downstream acks outside ACCESS
      slave_noise = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [2:0]  r_adr;
         logic        r_we;
         logic [3:0]  r_sel;
         logic [31:0] r_dat;
         int          r_w;
         r_adr = 3'($urandom);
         r_we  = 1'($urandom);
         r_sel = 4'($urandom);
         r_dat = $urandom;
         r_w   = $urandom_range(0, 5);
         slave_wait = r_w;
         model(r_adr, r_we, r_sel, r_dat, r_w, e_ack, e_err, e_cyc, e_rd);
         run_txn(r_adr, r_we, r_sel, r_dat, ack, err, cyc_n, rd);
         check("rand_ack", 32'(ack), 32'(e_ack));
         check("rand_err", 32'(err), 32'(e_err));
         check("rand_cycles", 32'(cyc_n), 32'(e_cyc));
         if (e_ack) check("rand_rdata", rd, e_rd);
         compare_log("rand");
      end
      slave_noise = 1'b0;

      check("ack_err_exclusive", 32'(both_cnt), 32'd0);
      check("sel_onehot_matches_adr", 32'(sel_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
